// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode/direction encodings and duty width for the LED pattern controller
package led_pattern_pkg;
   localparam int DUTY_W = 16;
   typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATH} mode_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: valid/ready config port carrying target channel, mode and rate
interface led_pattern_ctrl_if #(parameter int CH_W = 2);
   logic valid;
   logic ready;
   logic [CH_W-1:0] ch;
   logic [1:0] mode;
   logic [7:0] rate;
   modport master(output valid, ch, mode, rate, input ready);
   modport slave(input valid, ch, mode, rate, output ready);
endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel with shadowed config, period-end apply, tick divider, blink and breath ramp
module led_pwm_channel import led_pattern_pkg::*; #(
   parameter int PWM_PERIOD = 50000,
   parameter int DUTY_STEP = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [DUTY_W-1:0] period_cnt,
   input  logic period_end,
   input  logic wr_en,
   input  logic [1:0] wr_mode,
   input  logic [7:0] wr_rate,
   output logic led
);
   localparam logic [DUTY_W-1:0] TOP = DUTY_W'(PWM_PERIOD);
   localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(DUTY_STEP);
   mode_t mode, sh_mode;
   dir_t dir, dir_nx;
   logic [7:0] rate, sh_rate, tick_cnt;
   logic [DUTY_W-1:0] duty, duty_nx;
   logic pending, blink, apply, tick;
   assign apply = period_end & pending;
   assign tick = period_end & ~pending & (tick_cnt == rate);
   // breath ramp next state; the top compare is >= so a step that does not divide the period still turns around
   always_comb begin
      dir_nx = dir;
      duty_nx = duty;
      if (apply && sh_mode == MODE_BREATH) begin
         dir_nx = DIR_UP;
         duty_nx = '0;
      end else if (tick && mode == MODE_BREATH && dir == DIR_UP) begin
         dir_nx = (duty >= TOP) ? DIR_DOWN : DIR_UP;
         duty_nx = (duty >= TOP) ? duty : duty + STEP_V;
      end else if (tick && mode == MODE_BREATH) begin
         dir_nx = (duty == '0) ? DIR_UP : DIR_DOWN;
         duty_nx = (duty == '0) ? duty : duty - STEP_V;
      end
   end
   // breath direction and duty registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dir <= DIR_UP;
         duty <= '0;
      end else begin
         dir <= dir_nx;
         duty <= duty_nx;
      end
   // shadow capture, period-end apply, tick divider and blink toggle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sh_mode <= MODE_OFF;
         sh_rate <= '0;
         pending <= 1'b0;
         mode <= MODE_OFF;
         rate <= '0;
         tick_cnt <= '0;
         blink <= 1'b0;
      end else begin
         if (wr_en) begin
            sh_mode <= mode_t'(wr_mode);
            sh_rate <= wr_rate;
         end
         pending <= wr_en | (pending & ~period_end);
         if (apply) begin
            mode <= sh_mode;
            rate <= sh_rate;
         end
         tick_cnt <= (apply | tick) ? '0 : period_end ? tick_cnt + 1'b1 : tick_cnt;
         blink <= (apply && sh_mode == MODE_BLINK) ? 1'b0 : (tick && mode == MODE_BLINK) ? ~blink : blink;
      end
   assign led = (mode == MODE_ON) | (mode == MODE_BLINK & blink) | (mode == MODE_BREATH & period_cnt < duty);
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: shared PWM period counter and config decode feeding NUM_CH pattern channels
module led_pattern_ctrl import led_pattern_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int PWM_PERIOD = 50000,
   parameter int DUTY_STEP = 25,
   parameter int CH_W = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   led_pattern_ctrl_if.slave cfg,
   output logic [NUM_CH-1:0] led,
   output logic period_end
);
   localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PWM_PERIOD);
   logic [DUTY_W-1:0] period_cnt;
   logic started, xfer;
   // period counter with a registered end flag aligned to the last count, plus a post-reset ready gate
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         period_cnt <= '0;
         period_end <= 1'b0;
         started <= 1'b0;
      end else begin
         period_cnt <= (period_cnt == LAST) ? '0 : period_cnt + 1'b1;
         period_end <= (period_cnt == LAST - 1'b1);
         started <= 1'b1;
      end
   assign cfg.ready = started & ~period_end;
   assign xfer = cfg.valid & cfg.ready;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      led_pwm_channel #(.PWM_PERIOD(PWM_PERIOD), .DUTY_STEP(DUTY_STEP)) u_ch (
         .clk(sys_clk),
         .rst_n(sys_rst_n),
         .period_cnt(period_cnt),
         .period_end(period_end),
         .wr_en(xfer && cfg.ch == CH_W'(i)),
         .wr_mode(cfg.mode),
         .wr_rate(cfg.rate),
         .led(led[i])
      );
   end
endmodule
